// File: rtl/bp_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: dir_state_t 2-bit direction enum, BP_ENTRIES default table size,
//           XLEN machine word width, and an index helper.
package bp_pkg;

  localparam int XLEN       = 32;
  localparam int BP_ENTRIES = 64;

  // Two-bit saturating direction state; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } dir_state_t;

  // True when a direction state predicts taken.
  function automatic logic state_taken(input dir_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
// Latency: purely combinational.
// Backpressure: none; output always reflects the current inputs.
// Ports: cur  - present direction state
//        taken - resolved direction (1 steps up, 0 steps down)
//        nxt  - state after the step, saturating at ST and SNT
module sat_counter2
  import bp_pkg::*;
(
  input  dir_state_t cur,
  input  logic       taken,
  output dir_state_t nxt
);

  always_comb begin
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with tagged target buffer and stats.
// Latency: prediction is combinational from table state; updates visible the cycle after the edge.
// Backpressure: none; one update accepted every cycle upd_valid is high.
// Ports: clk, rst_n (synchronous, active-low)
//        pred_pc -> pred_taken, pred_target, pred_hit   (fetch-side lookup)
//        upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken (resolve-side training)
//        stat_branches, stat_mispred (saturating counters)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_hit,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Table kept in flops so every entry can be cleared in the reset cycle.
  dir_state_t             state_q  [ENTRIES];
  logic [ENTRIES-1:0]     valid_q;
  logic [TAG_W-1:0]       tag_q    [ENTRIES];
  logic [XLEN-1:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] ptag;
  logic [TAG_W-1:0] utag;

  // PCs are word aligned; the two low bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  assign pidx = pred_pc[IDX_W+1:2];
  assign ptag = pred_pc[XLEN-1:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[XLEN-1:IDX_W+2];

  // ---------------------------------------------------------------- lookup
  // No bypass from the update port: a same-index lookup sees old state.
  logic hit_c;
  assign hit_c       = valid_q[pidx] & (tag_q[pidx] == ptag);
  assign pred_hit    = hit_c;
  assign pred_taken  = hit_c & state_taken(state_q[pidx]);
  assign pred_target = pred_taken ? target_q[pidx] : pred_pc + 32'd4;

  // ---------------------------------------------------------------- update
  dir_state_t upd_cur;
  dir_state_t upd_nxt;
  assign upd_cur = state_q[uidx];

  sat_counter2 u_sat_counter2 (
    .cur   (upd_cur),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  // Direction state trains on every resolved branch, even on a tag miss,
  // so aliasing branches deliberately share one counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= WNT;
      end
      valid_q       <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      state_q[uidx] <= upd_nxt;
      if (upd_taken) begin
        valid_q[uidx] <= 1'b1;
      end
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if ((upd_taken != upd_pred_taken) && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

  // Tag/target are qualified by valid_q, so they carry no reset; a write
  // coinciding with reset is suppressed so the discarded update leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid && upd_taken) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES = 64).
// Latency: inputs driven 1 ns after the rising edge, outputs compared 2 ns after.
// Backpressure: n/a.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_assert = 0;
  int n_fail   = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_hit       (pred_hit),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change at edge+1, compare point is edge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = ptk;
    tick();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [8:0] pat_tk;
  logic [8:0] pat_exp;

  initial begin
    rst_n          = 1'b0;
    pred_pc        = 32'h0000_1000;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_pred_taken = 1'b0;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_hit",      {31'd0, pred_hit},   32'd0);
    check("rst_taken",    {31'd0, pred_taken}, 32'd0);
    check("rst_target",   pred_target,         32'h0000_1004);
    check("rst_branches", stat_branches,       32'd0);
    check("rst_mispred",  stat_mispred,        32'd0);

    // Two taken updates, both originally mispredicted
    pred_pc = 32'h0000_0100;
    upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    check("train_hit",      {31'd0, pred_hit},   32'd1);
    check("train_taken",    {31'd0, pred_taken}, 32'd1);
    check("train_target",   pred_target,         32'h0000_0080);
    check("train_branches", stat_branches,       32'd2);
    check("train_mispred",  stat_mispred,        32'd2);

    // Low PC bits ignored
    pred_pc = 32'h0000_0102;
    #1;
    check("lsb_hit", {31'd0, pred_hit}, 32'd1);

    // Same index, different tag
    pred_pc = 32'h0000_0200;
    #1;
    check("alias_hit",    {31'd0, pred_hit},   32'd0);
    check("alias_taken",  {31'd0, pred_taken}, 32'd0);
    check("alias_target", pred_target,         32'h0000_0204);

    // upd_valid low: nothing changes even with live-looking update inputs
    pred_pc        = 32'h0000_0100;
    upd_pc         = 32'h0000_0100;
    upd_taken      = 1'b0;
    upd_pred_taken = 1'b1;
    tick();
    #1;
    check("idle_branches", stat_branches,       32'd2);
    check("idle_mispred",  stat_mispred,        32'd2);
    check("idle_taken",    {31'd0, pred_taken}, 32'd1);

    // Reset concurrent with an update: update discarded
    rst_n          = 1'b0;
    upd_valid      = 1'b1;
    upd_pc         = 32'h0000_0100;
    upd_taken      = 1'b1;
    upd_target     = 32'h0000_0999;
    upd_pred_taken = 1'b0;
    tick();
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    #1;
    check("rstupd_hit",      {31'd0, pred_hit},   32'd0);
    check("rstupd_taken",    {31'd0, pred_taken}, 32'd0);
    check("rstupd_target",   pred_target,         32'h0000_0104);
    check("rstupd_branches", stat_branches,       32'd0);
    check("rstupd_mispred",  stat_mispred,        32'd0);

    // Direction walk at 0x100 from WNT:
    // T:WT T:ST T:ST T:ST N:WT N:WNT N:SNT T:WNT T:WT
    pat_tk  = 9'b110001111;  // bit i = direction of step i
    pat_exp = 9'b100011111;  // bit i = pred_taken after step i
    for (int i = 0; i < 9; i++) begin
      upd(32'h0000_0100, pat_tk[i], 32'h0000_0080, 1'b1);
      check($sformatf("walk_hit_%0d", i),   {31'd0, pred_hit},   32'd1);
      check($sformatf("walk_taken_%0d", i), {31'd0, pred_taken}, {31'd0, pat_exp[i]});
    end
    check("walk_target",   pred_target,   32'h0000_0080);
    check("walk_branches", stat_branches, 32'd9);
    check("walk_mispred",  stat_mispred,  32'd3);

    // Aliased not-taken update: shared counter WT->WNT, tag/target untouched
    upd(32'h0000_0200, 1'b0, 32'h0000_0555, 1'b0);
    check("aliasnt_hit",    {31'd0, pred_hit},   32'd1);
    check("aliasnt_taken",  {31'd0, pred_taken}, 32'd0);
    check("aliasnt_target", pred_target,         32'h0000_0104);
    check("aliasnt_mispred", stat_mispred,       32'd3);

    // Same-cycle update and lookup at index(0x40): no bypass
    do_reset();
    pred_pc        = 32'h0000_0040;
    upd_valid      = 1'b1;
    upd_pc         = 32'h0000_0040;
    upd_taken      = 1'b1;
    upd_target     = 32'h0000_0400;
    upd_pred_taken = 1'b0;
    #1;
    check("bypass_now_taken", {31'd0, pred_taken}, 32'd0);
    check("bypass_now_hit",   {31'd0, pred_hit},   32'd0);
    tick();
    upd_valid = 1'b0;
    #1;
    check("bypass_next_taken",  {31'd0, pred_taken}, 32'd1);
    check("bypass_next_target", pred_target,         32'h0000_0400);

    // Fall-through target wraps modulo 2^32
    pred_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_target", pred_target, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
